// File: rtl/tinker_exec_unit.sv
// Clocked Tinker integer execution unit: single-cycle simple ops plus
// iterative shift-add multiply and restoring divide behind valid/ready handshakes.
module tinker_exec_unit #(
    parameter int W     = 64,
    parameter int LIT_W = 12,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_opcode,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [LIT_W-1:0] in_lit,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);
    localparam int LOG2W = $clog2(W);
    localparam int CW    = LOG2W + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W);

    localparam logic [4:0] OP_ADD   = 5'b11000;
    localparam logic [4:0] OP_SUB   = 5'b11010;
    localparam logic [4:0] OP_MUL   = 5'b11100;
    localparam logic [4:0] OP_DIV   = 5'b11101;
    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_OR    = 5'b00001;
    localparam logic [4:0] OP_XOR   = 5'b00010;
    localparam logic [4:0] OP_NOT   = 5'b00011;
    localparam logic [4:0] OP_SHR   = 5'b00100;
    localparam logic [4:0] OP_SHL   = 5'b00110;
    localparam logic [4:0] OP_MOV   = 5'b10001;
    localparam logic [4:0] OP_MOVL  = 5'b10010;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    a_q;      // multiplicand (MUL) or dividend/quotient (DIV)
    logic [W-1:0]    b_q;      // multiplier (MUL) or divisor (DIV)
    logic [W-1:0]    acc_q;    // partial product (MUL) or remainder (DIV)
    logic            dz_q;
    logic [W-1:0]    result_q;
    logic [TAG_W-1:0] tag_q;
    logic            err_q;

    logic            accept;
    logic [W-1:0]    simple_res;
    logic            simple_err;
    logic            shamt_ok;
    logic [W:0]      rem_sh;
    logic [W:0]      rem_sub;
    logic            rem_ge;

    assign accept   = in_valid && in_ready;
    // Shift amounts of W or more must yield zero rather than wrap.
    assign shamt_ok = ~|in_b[W-1:LOG2W];

    always_comb begin
        simple_res = '0;
        simple_err = 1'b0;
        case (in_opcode)
            OP_ADD:  simple_res = in_a + in_b;
            OP_SUB:  simple_res = in_a - in_b;
            OP_AND:  simple_res = in_a & in_b;
            OP_OR:   simple_res = in_a | in_b;
            OP_XOR:  simple_res = in_a ^ in_b;
            OP_NOT:  simple_res = ~in_a;
            OP_SHR:  simple_res = shamt_ok ? (in_a >> in_b[LOG2W-1:0]) : '0;
            OP_SHL:  simple_res = shamt_ok ? (in_a << in_b[LOG2W-1:0]) : '0;
            OP_MOV:  simple_res = in_a;
            OP_MOVL: simple_res = {{(W-LIT_W){1'b0}}, in_lit};
            OP_MUL, OP_DIV: simple_res = '0;
            default: simple_err = 1'b1;
        endcase
    end

    // One restoring-division step: shift in next dividend bit, subtract if it fits.
    assign rem_sh  = {acc_q, a_q[W-1]};
    assign rem_ge  = rem_sh >= {1'b0, b_q};
    assign rem_sub = rem_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (in_opcode == OP_MUL)      state_d = S_MUL;
                    else if (in_opcode == OP_DIV) state_d = S_DIV;
                    else                          state_d = S_DONE;
                end else if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
        out_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            dz_q     <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            tag_q <= in_tag;
            cnt_q <= '0;
            a_q   <= in_a;
            b_q   <= in_b;
            acc_q <= '0;
            dz_q  <= (in_b == '0);
            if (in_opcode != OP_MUL && in_opcode != OP_DIV) begin
                result_q <= simple_res;
                err_q    <= simple_err;
            end
        end else if (state_q == S_MUL) begin
            if (cnt_q != CNT_LAST) begin
                acc_q <= acc_q + (b_q[0] ? a_q : '0);
                a_q   <= a_q << 1;
                b_q   <= b_q >> 1;
                cnt_q <= cnt_q + 1'b1;
            end else begin
                result_q <= acc_q;
                err_q    <= 1'b0;
            end
        end else if (state_q == S_DIV) begin
            if (cnt_q != CNT_LAST) begin
                acc_q <= rem_sub[W-1:0];
                a_q   <= {a_q[W-2:0], rem_ge};
                cnt_q <= cnt_q + 1'b1;
            end else begin
                result_q <= dz_q ? '1 : a_q;
                err_q    <= dz_q;
            end
        end
    end

    assign out_result = result_q;
    assign out_tag    = tag_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_tinker_exec_unit.sv
// Directed bench for tinker_exec_unit: handshake, latency, arithmetic and error cases.
module tb_tinker_exec_unit;
    localparam int W = 64;
    localparam int LIT_W = 12;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       in_opcode = '0;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic [LIT_W-1:0] in_lit = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    int total = 0;
    int bad = 0;

    tinker_exec_unit #(.W(W), .LIT_W(LIT_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b), .in_lit(in_lit), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Called at posedge+1; returns edges after the accept edge until out_valid.
    task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [LIT_W-1:0] lit, input logic [TAG_W-1:0] tag,
                         output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) check("ready_timeout", 64'd0, 64'd1);
        in_opcode = op; in_a = a; in_b = b; in_lit = lit; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    int lat;
    int seen;

    initial begin
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_result", out_result, 64'd0);
        check("rst_tag", {59'd0, out_tag}, 64'd0);
        check("rst_err", {63'd0, out_err}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // add wrapping
        do_op(5'b11000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, '0, 5'd7, lat);
        check("add_lat", 64'(lat), 64'd0);
        check("add_res", out_result, 64'd1);
        check("add_tag", {59'd0, out_tag}, 64'd7);
        check("add_err", {63'd0, out_err}, 64'd0);
        @(posedge clk); #1;
        check("add_drop", {63'd0, out_valid}, 64'd0);

        // back-to-back add then sub
        in_opcode = 5'b11000; in_a = 64'd1; in_b = 64'd2; in_tag = 5'd1; in_valid = 1'b1;
        check("b2b_ready0", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        check("b2b_add_v", {63'd0, out_valid}, 64'd1);
        check("b2b_add_res", out_result, 64'd3);
        check("b2b_ready1", {63'd0, in_ready}, 64'd1);
        in_opcode = 5'b11010; in_a = 64'd3; in_b = 64'd5; in_tag = 5'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_sub_v", {63'd0, out_valid}, 64'd1);
        check("b2b_sub_res", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("b2b_sub_tag", {59'd0, out_tag}, 64'd2);
        @(posedge clk); #1;
        check("b2b_idle", {63'd0, out_valid}, 64'd0);

        // multiply latency and ready low while iterating
        in_opcode = 5'b11100; in_a = 64'h1_0000_0001; in_b = 64'h1_0000_0001; in_tag = 5'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        seen = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) seen++;
            @(posedge clk); #1; lat++;
        end
        check("mul_lat", 64'(lat), 64'd65);
        check("mul_ready_busy", 64'(seen), 64'd0);
        check("mul_res", out_result, 64'h0000_0002_0000_0001);
        check("mul_tag", {59'd0, out_tag}, 64'd3);
        check("mul_err", {63'd0, out_err}, 64'd0);
        @(posedge clk); #1;

        // divide
        do_op(5'b11101, 64'd100, 64'd7, '0, 5'd4, lat);
        check("div_lat", 64'(lat), 64'd65);
        check("div_res", out_result, 64'd14);
        check("div_err", {63'd0, out_err}, 64'd0);
        @(posedge clk); #1;
        do_op(5'b11101, 64'd5, 64'd0, '0, 5'd5, lat);
        check("div0_lat", 64'(lat), 64'd65);
        check("div0_res", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("div0_err", {63'd0, out_err}, 64'd1);
        @(posedge clk); #1;
        do_op(5'b11101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, '0, 5'd6, lat);
        check("div_big", out_result, 64'h0FFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;

        // backpressure on shftl
        out_ready = 1'b0;
        do_op(5'b00110, 64'd1, 64'd63, '0, 5'd9, lat);
        check("shl_lat", 64'(lat), 64'd0);
        for (int i = 0; i < 5; i++) begin
            check("bp_res", out_result, 64'h8000_0000_0000_0000);
            check("bp_ready", {63'd0, in_ready}, 64'd0);
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            @(posedge clk); #1;
        end
        check("bp_tag", {59'd0, out_tag}, 64'd9);
        out_ready = 1'b1;
        @(posedge clk); #1;

        do_op(5'b00100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64, '0, 5'd10, lat);
        check("shr64_res", out_result, 64'd0);
        @(posedge clk); #1;
        do_op(5'b00100, 64'hF000_0000_0000_0000, 64'd60, '0, 5'd10, lat);
        check("shr60_res", out_result, 64'd15);
        @(posedge clk); #1;
        do_op(5'b10010, 64'h1234_5678_9ABC_DEF0, 64'd0, 12'hABC, 5'd11, lat);
        check("movl_res", out_result, 64'hABC);
        check("movl_err", {63'd0, out_err}, 64'd0);
        @(posedge clk); #1;
        do_op(5'b00010, 64'hF0F0, 64'hFF00, '0, 5'd12, lat);
        check("xor_res", out_result, 64'h0FF0);
        @(posedge clk); #1;
        do_op(5'b11111, 64'd5, 64'd6, '0, 5'd13, lat);
        check("ill_lat", 64'(lat), 64'd0);
        check("ill_res", out_result, 64'd0);
        check("ill_err", {63'd0, out_err}, 64'd1);
        @(posedge clk); #1;

        // asynchronous reset in the middle of a multiply
        in_opcode = 5'b11100; in_a = 64'd3; in_b = 64'd4; in_tag = 5'd14; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("amid_valid", {63'd0, out_valid}, 64'd0);
        check("amid_ready", {63'd0, in_ready}, 64'd1);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("amid_no_stale", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
